// File: rtl/pattern_scheduler.sv
// Frame-synchronous pattern selector: debounced switches, step requests and an
// auto-cycle mode, all committed to pat_sel only at vSync frame boundaries.
module pattern_scheduler #(
    parameter int   NUM_PAT   = 8,
    parameter int   DWELL     = 60,
    parameter int   DEBOUNCE  = 3,
    parameter logic VS_ACTIVE = 1'b0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        vSync,
    input  logic [2:0]  SW,
    input  logic        auto_en,
    input  logic        step,
    output logic [2:0]  pat_sel,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic        pending
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        AUTO_ENTER = 2'd1,
        AUTO       = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           vs_q, vs_d;
    logic           armed_q, armed_d;
    logic [2:0]     sw_m_q, sw_m_d;
    logic [2:0]     sw_s_q, sw_s_d;
    logic           auto_m_q, auto_m_d;
    logic           auto_s_q, auto_s_d;
    logic [2:0]     sw_last_q, sw_last_d;
    logic [CW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [2:0]     acc_q, acc_d;
    logic [2:0]     target_q, target_d;
    logic [2:0]     pat_sel_q, pat_sel_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic           frame_tick_q, frame_tick_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           pending_q, pending_d;

    logic           frame_edge;
    logic           accept;
    logic [2:0]     acc_pat;
    logic [2:0]     target_base;

    function automatic logic [2:0] next_pat(input logic [2:0] v);
        return (int'(v) >= NUM_PAT - 1) ? 3'd0 : v + 3'd1;
    endfunction

    function automatic logic [2:0] clamp_pat(input logic [2:0] v);
        return (int'(v) >= NUM_PAT) ? 3'(NUM_PAT - 1) : v;
    endfunction

    // armed_q blocks a spurious edge right after reset when vSync is already
    // asserted: a real inactive sample must be seen first.
    assign frame_edge = (vSync == VS_ACTIVE) && (vs_q != VS_ACTIVE) && armed_q;

    always_comb begin
        vs_d         = vSync;
        armed_d      = armed_q | (vSync != VS_ACTIVE);
        sw_m_d       = SW;
        sw_s_d       = sw_m_q;
        auto_m_d     = auto_en;
        auto_s_d     = auto_m_q;
        frame_tick_d = frame_edge;
        frame_cnt_d  = frame_edge ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_comb begin
        sw_last_d = sw_last_q;
        deb_cnt_d = deb_cnt_q;
        acc_d     = acc_q;
        accept    = 1'b0;
        if (frame_edge) begin
            if (sw_s_q == sw_last_q) begin
                if (deb_cnt_q < DEB_MAX) begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
                if ((deb_cnt_d >= DEB_MAX) && (sw_last_q != acc_q)) begin
                    accept = 1'b1;
                    acc_d  = sw_last_q;
                end
            end else begin
                deb_cnt_d = '0;
                sw_last_d = sw_s_q;
            end
        end
    end

    assign acc_pat = clamp_pat(sw_last_q);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MANUAL: begin
                if (auto_s_q) state_d = AUTO_ENTER;
            end
            AUTO_ENTER: begin
                if (!auto_s_q)       state_d = MANUAL;
                else if (frame_edge) state_d = AUTO;
            end
            AUTO: begin
                if (!auto_s_q) state_d = MANUAL;
            end
            default: state_d = MANUAL;
        endcase
    end

    // A freshly accepted switch value is committed on the same tick it is
    // accepted; steps always land in target and wait for the next tick.
    always_comb begin
        pat_sel_d   = pat_sel_q;
        dwell_d     = dwell_q;
        target_base = target_q;
        if (frame_edge) begin
            case (state_q)
                MANUAL: begin
                    if (accept) begin
                        target_base = acc_pat;
                        pat_sel_d   = acc_pat;
                    end else begin
                        pat_sel_d   = target_q;
                    end
                end
                AUTO_ENTER: begin
                    pat_sel_d = target_q;
                    dwell_d   = '0;
                end
                AUTO: begin
                    if (target_q != pat_sel_q) begin
                        pat_sel_d = target_q;
                        dwell_d   = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        pat_sel_d   = next_pat(pat_sel_q);
                        target_base = next_pat(pat_sel_q);
                        dwell_d     = '0;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                default: pat_sel_d = pat_sel_q;
            endcase
        end
        target_d  = step ? next_pat(target_base) : target_base;
        pending_d = (target_q != pat_sel_q);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            vs_q         <= ~VS_ACTIVE;
            armed_q      <= 1'b0;
            sw_m_q       <= '0;
            sw_s_q       <= '0;
            auto_m_q     <= 1'b0;
            auto_s_q     <= 1'b0;
            sw_last_q    <= '0;
            deb_cnt_q    <= '0;
            acc_q        <= '0;
            target_q     <= '0;
            pat_sel_q    <= '0;
            dwell_q      <= '0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
            pending_q    <= 1'b0;
        end else begin
            vs_q         <= vs_d;
            armed_q      <= armed_d;
            sw_m_q       <= sw_m_d;
            sw_s_q       <= sw_s_d;
            auto_m_q     <= auto_m_d;
            auto_s_q     <= auto_s_d;
            sw_last_q    <= sw_last_d;
            deb_cnt_q    <= deb_cnt_d;
            acc_q        <= acc_d;
            target_q     <= target_d;
            pat_sel_q    <= pat_sel_d;
            dwell_q      <= dwell_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
            pending_q    <= pending_d;
        end
    end

    assign pat_sel    = pat_sel_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler: an 8-pattern and a 6-pattern instance
// share stimulus; each frame row carries its expected committed patterns.
module tb_pattern_scheduler;

    logic        clock = 1'b0;
    logic        rst;
    logic        vSync;
    logic [2:0]  SW;
    logic        auto_en;
    logic        step;

    logic [2:0]  pat8, pat6;
    logic        tick8, tick6;
    logic [15:0] cnt8, cnt6;
    logic        pend8, pend6;

    int n_checks = 0;
    int n_err    = 0;
    int exp_fc   = 0;

    always #5 clock = ~clock;

    pattern_scheduler #(.NUM_PAT(8), .DWELL(2), .DEBOUNCE(3), .VS_ACTIVE(1'b0)) dut8 (
        .clock(clock), .rst(rst), .vSync(vSync), .SW(SW), .auto_en(auto_en), .step(step),
        .pat_sel(pat8), .frame_tick(tick8), .frame_cnt(cnt8), .pending(pend8)
    );

    pattern_scheduler #(.NUM_PAT(6), .DWELL(2), .DEBOUNCE(3), .VS_ACTIVE(1'b0)) dut6 (
        .clock(clock), .rst(rst), .vSync(vSync), .SW(SW), .auto_en(auto_en), .step(step),
        .pat_sel(pat6), .frame_tick(tick6), .frame_cnt(cnt6), .pending(pend6)
    );

    typedef struct {
        logic [2:0] sw;
        logic       auto_v;
        logic [2:0] exp8;
        logic [2:0] exp6;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: inactive vSync with optional step pulses, then the edge cycle.
    // Returns just after the commit edge; pend/pat are sampled before the edge.
    task automatic run_frame(input int nsteps, input bit edge_step,
                             output logic pend_before, output logic [2:0] pat_before);
        vSync = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int s = 0; s < nsteps; s++) begin
            step = 1'b1;
            @(posedge clock); #1;
            step = 1'b0;
            @(posedge clock); #1;
        end
        repeat (2) @(posedge clock);
        #1;
        pend_before = pend8;
        pat_before  = pat8;
        vSync = 1'b0;
        step  = edge_step;
        @(posedge clock); #1;
        step  = 1'b0;
        exp_fc++;
    endtask

    initial begin
        logic       pb;
        logic [2:0] patb;
        int         ticks_seen;

        for (int i = 0; i < 4; i++)  tbl[i]      = '{3'd5, 1'b0, 3'd0, 3'd0};
        tbl[3]  = '{3'd5, 1'b0, 3'd5, 3'd5};
        for (int i = 4; i < 8; i++)  tbl[i]      = '{3'd3, 1'b0, 3'd5, 3'd5};
        tbl[7]  = '{3'd3, 1'b0, 3'd3, 3'd3};
        for (int i = 8; i < 12; i++) tbl[i]      = '{3'd7, 1'b0, 3'd3, 3'd3};
        tbl[11] = '{3'd7, 1'b0, 3'd7, 3'd5};
        for (int i = 12; i < 16; i++) tbl[i]     = '{3'd6, 1'b0, 3'd7, 3'd5};
        tbl[15] = '{3'd6, 1'b0, 3'd6, 3'd5};
        tbl[16] = '{3'd6, 1'b1, 3'd6, 3'd5};
        tbl[17] = '{3'd6, 1'b1, 3'd6, 3'd5};
        tbl[18] = '{3'd6, 1'b1, 3'd7, 3'd0};
        tbl[19] = '{3'd6, 1'b1, 3'd7, 3'd0};
        tbl[20] = '{3'd6, 1'b1, 3'd0, 3'd1};
        tbl[21] = '{3'd6, 1'b1, 3'd0, 3'd1};
        tbl[22] = '{3'd6, 1'b1, 3'd1, 3'd2};
        tbl[23] = '{3'd6, 1'b0, 3'd1, 3'd2};
        tbl[24] = '{3'd6, 1'b0, 3'd1, 3'd2};

        rst = 1'b1; vSync = 1'b1; SW = 3'd0; auto_en = 1'b0; step = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset pat_sel",    int'(pat8),  0);
        chk("reset frame_tick", int'(tick8), 0);
        chk("reset frame_cnt",  int'(cnt8),  0);
        chk("reset pending",    int'(pend8), 0);
        chk("reset pat_sel6",   int'(pat6),  0);
        chk("reset frame_cnt6", int'(cnt6) + int'(tick6) + int'(pend6), 0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            SW      = tbl[i].sw;
            auto_en = tbl[i].auto_v;
            run_frame(0, 1'b0, pb, patb);
            chk($sformatf("row%0d pat8", i), int'(pat8), int'(tbl[i].exp8));
            chk($sformatf("row%0d pat6", i), int'(pat6), int'(tbl[i].exp6));
            chk($sformatf("row%0d tick", i), int'(tick8), 1);
            chk($sformatf("row%0d frame_cnt", i), int'(cnt8), exp_fc);
        end

        run_frame(1, 1'b0, pb, patb);
        chk("step1 pat8", int'(pat8), 2);
        chk("step1 pat6", int'(pat6), 3);

        run_frame(3, 1'b0, pb, patb);
        chk("step3 pending before", int'(pb), 1);
        chk("step3 pat before", int'(patb), 2);
        chk("step3 pat8", int'(pat8), 5);
        chk("step3 pat6 wrap", int'(pat6), 0);
        @(posedge clock); #1;
        chk("tick one cycle", int'(tick8), 0);

        run_frame(0, 1'b0, pb, patb);
        chk("after step pending", int'(pb), 0);
        chk("after step pat8", int'(pat8), 5);

        run_frame(0, 1'b1, pb, patb);
        chk("edge step pat8 held", int'(pat8), 5);
        chk("edge step pat6 held", int'(pat6), 0);
        run_frame(0, 1'b0, pb, patb);
        chk("edge step pat8 next", int'(pat8), 6);
        chk("edge step pat6 next", int'(pat6), 1);

        // reset mid-frame with vSync held asserted
        vSync = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("midrst pat_sel",   int'(pat8),  0);
        chk("midrst frame_cnt", int'(cnt8),  0);
        chk("midrst pending",   int'(pend8), 0);
        rst = 1'b0;
        ticks_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            ticks_seen += int'(tick8);
        end
        chk("midrst no tick", ticks_seen, 0);
        vSync = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("midrst still no tick", int'(tick8), 0);
        vSync = 1'b0;
        @(posedge clock); #1;
        chk("midrst first tick", int'(tick8), 1);
        chk("midrst frame_cnt 1", int'(cnt8), 1);
        chk("midrst pat after", int'(pat8), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_PAT, 8: number of selectable patterns, 2..8.
- DWELL, 60: frames per pattern in auto mode, >=1.
- DEBOUNCE, 3: consecutive stable frame ticks before a switch change is accepted, >=1.
- VS_ACTIVE, 0: asserted level of vSync.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: pixel clock, the only clock.
- rst, in, 1: reset, synchronous, active-high.
- vSync, in, 1: vertical sync from the timing controller.
- SW, in, 3: asynchronous pattern-select switches.
- auto_en, in, 1: asynchronous auto-cycle enable.
- step, in, 1: single-cycle synchronous advance request.
- pat_sel, out, 3: committed pattern index to the pattern generator.
- frame_tick, out, 1: one-cycle pulse per frame boundary.
- frame_cnt, out, 16: frame counter.
- pending, out, 1: high while target differs from pat_sel.

Function
REQ-003 The block SHALL register vSync into vs_q; edge = (vSync==VS_ACTIVE) && (vs_q!=VS_ACTIVE).
REQ-004 On the clock edge ending an edge cycle, the block SHALL set frame_tick=1 for exactly one cycle, increment frame_cnt with wrap 0xFFFF->0, and commit pattern changes; latency from the first asserted vSync sample is 1 clock.
REQ-005 pat_sel SHALL change only on a commit edge (REQ-004), never mid-frame.
REQ-006 SW and auto_en SHALL each pass through a two-flop synchronizer (sw_s, auto_s) before use.
REQ-007 Debounce SHALL work as follows:
- At each frame tick, sw_s is compared with sw_last; equal -> stable count +1 (saturating), different -> count=0 and sw_last=sw_s.
- The value is accepted when the count reaches DEBOUNCE and sw_last differs from the previously accepted value.
REQ-008 An accepted switch value >= NUM_PAT SHALL clamp to NUM_PAT-1.
REQ-009 The FSM SHALL have states MANUAL, AUTO_ENTER and AUTO, with these transitions:
- MANUAL->AUTO_ENTER when auto_s=1.
- AUTO_ENTER->AUTO on frame tick, with dwell_cnt=0.
- AUTO_ENTER or AUTO->MANUAL when auto_s=0, effective the next cycle; pat_sel is unchanged.
REQ-010 In MANUAL, target SHALL load an accepted switch value only when that value is newly accepted; a step-selected target persists until the next acceptance.
REQ-011 step SHALL set target=(target+1) mod NUM_PAT in any state; multiple steps within one frame accumulate.
REQ-012 A commit SHALL use the target value held before that cycle's updates; a step coinciding with the edge cycle is committed at the following frame tick.
REQ-013 At each AUTO frame tick the block SHALL apply, in priority order:
- pending -> pat_sel=target, dwell_cnt=0.
- else dwell_cnt==DWELL-1 -> pat_sel=target=(pat_sel+1) mod NUM_PAT, dwell_cnt=0.
- else dwell_cnt+1.
REQ-014 In MANUAL and AUTO_ENTER, each frame tick SHALL set pat_sel=target.
REQ-015 pending SHALL be the registered value of (target != pat_sel).
REQ-016 Wrap: NUM_PAT-1 advances to 0 for both step and auto advance.

Reset
REQ-017 While rst=1 the block SHALL drive these values:
- pat_sel=0, target=0, frame_tick=0, frame_cnt=0, pending=0.
- state=MANUAL, dwell_cnt=0, debounce count=0, sw_last=0.
- synchronizer flops=0, vs_q=~VS_ACTIVE.
REQ-018 After reset deassertion, including reset asserted mid-frame, no frame_tick SHALL occur until vSync is first sampled at VS_ACTIVE following a sample at ~VS_ACTIVE.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then SW=5 held 4 frames, DEBOUNCE=3 -> pat_sel 0 through tick 3, 5 at tick 4 (first tick after SW reaches sw_s only samples it).
- SW=7 with NUM_PAT=6 held -> pat_sel=5 after acceptance.
- auto_en=1, DWELL=2, start pat_sel=6, NUM_PAT=8 -> AUTO_ENTER one tick, then pat_sel 7 then 0 every 2 ticks.
- Three step pulses within one frame from pat_sel=2 -> pending=1, pat_sel=5 at the next tick only.
- step in the edge cycle -> pat_sel unchanged at that tick, +1 at the next tick.
- rst mid-frame with vSync held asserted -> no frame_tick until vSync deasserts and reasserts; frame_cnt=1 at that tick.
